mac_operand_sequencer: RTL and testbench

MAC_OPERAND_SEQUENCER -- requirements
Module: mac_operand_sequencer

---
 rtl/mac_operand_sequencer.sv | 224 ++++++++++++++++++++++
 tb/tb_mac_operand_sequencer.sv | 361 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mac_operand_sequencer.sv
// Purpose : buffers packed operand pairs in a FIFO and streams one job of up to
//           DEPTH pairs into an external multiply-accumulator, then returns the
//           accumulator value through a valid/ready result port.
// Latency : with no stalls, CLEAR is cycle 1 after start, STREAM cycles 2..len+1,
//           CAPTURE cycle len+2, res_valid from cycle len+3; each empty-FIFO stall adds 1.
// Backpr. : in_ready drops when the FIFO is full (no pass-through); the result
//           is held in DONE until res_ready, and start is ignored while busy.
//
// Ports:
//   clk, rst          clock (rising edge), asynchronous active-high reset
//   in_valid/in_data/in_ready   operand pair push, in_data[3:0]=a, [7:4]=b
//   start, len        single-cycle job request and number of pairs (clamped to DEPTH)
//   busy              high whenever the sequencer is not idle
//   mac_a, mac_b      operands to the accumulator (zero when not streaming a pair)
//   mac_clr           accumulator clear, high for the single CLEAR cycle
//   mac_c             registered accumulator value
//   res_valid/res_data/res_ready  result handshake
//   res_ovf           only with MAC_SEQ_OVF_FLAG_EN: shadow sum of products exceeded 255
//
// Optional feature macro: MAC_SEQ_OVF_FLAG_EN (adds res_ovf and an 11-bit shadow sum).

module mac_operand_sequencer #(
    parameter int DEPTH = 8,
    parameter int LEN_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [7:0]       in_data,
    output logic             in_ready,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    output logic             busy,
    output logic [3:0]       mac_a,
    output logic [3:0]       mac_b,
    output logic             mac_clr,
    input  logic [7:0]       mac_c,
    output logic             res_valid,
    output logic [7:0]       res_data,
    input  logic             res_ready
`ifdef MAC_SEQ_OVF_FLAG_EN
    ,
    output logic             res_ovf
`endif
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_CLEAR   = 3'd1,
        S_STREAM  = 3'd2,
        S_CAPTURE = 3'd3,
        S_DONE    = 3'd4
    } state_t;

    state_t r_state;
    state_t w_next;

    // ------------------------------------------------------------------
    // Operand FIFO
    // ------------------------------------------------------------------
    logic [7:0]    r_mem [DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;

    logic          w_push;
    logic          w_pop;
    logic          w_empty;
    logic [7:0]    w_head;

    assign in_ready = (r_count < CW'(DEPTH));
    assign w_push   = in_valid && in_ready;
    assign w_empty  = (r_count == '0);
    // A pair pushed this cycle is not visible until the next one, so an empty
    // FIFO always stalls even if in_valid is high.
    assign w_pop    = (r_state == S_STREAM) && !w_empty;
    assign w_head   = r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= in_data;
        end
    end

    // Pointers are exactly log2(DEPTH) bits wide, so they wrap on their own.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Job length: clamp to what the FIFO can ever hold
    // ------------------------------------------------------------------
    logic [CW-1:0] w_len_clamped;
    logic [CW-1:0] r_rem;

    always_comb begin
        w_len_clamped = CW'(len);
        if (32'(len) > DEPTH) begin
            w_len_clamped = CW'(DEPTH);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rem <= '0;
        end else if ((r_state == S_IDLE) && start) begin
            r_rem <= w_len_clamped;
        end else if (w_pop) begin
            r_rem <= r_rem - CW'(1);
        end
    end

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // FSM: next state
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_next = S_CLEAR;
                end
            end
            S_CLEAR: begin
                w_next = (r_rem == '0) ? S_CAPTURE : S_STREAM;
            end
            S_STREAM: begin
                if (w_pop && (r_rem == CW'(1))) begin
                    w_next = S_CAPTURE;
                end
            end
            S_CAPTURE: begin
                w_next = S_DONE;
            end
            S_DONE: begin
                if (res_ready) begin
                    w_next = S_IDLE;
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // FSM: outputs
    always_comb begin
        busy      = (r_state != S_IDLE);
        mac_clr   = (r_state == S_CLEAR);
        res_valid = (r_state == S_DONE);
        mac_a     = 4'd0;
        mac_b     = 4'd0;
        if (w_pop) begin
            mac_a = w_head[3:0];
            mac_b = w_head[7:4];
        end
    end

    // ------------------------------------------------------------------
    // Result register: the accumulator has absorbed the last product by the
    // CAPTURE cycle, so mac_c is sampled there and held through DONE.
    // ------------------------------------------------------------------
    logic [7:0] r_res_data;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_res_data <= 8'd0;
        end else if (r_state == S_CAPTURE) begin
            r_res_data <= mac_c;
        end
    end

    assign res_data = r_res_data;

`ifdef MAC_SEQ_OVF_FLAG_EN
    // Shadow sum of products wide enough for DEPTH*225 without wrapping, used
    // only to flag that the 8-bit accumulator result has wrapped.
    logic [10:0] r_shadow;
    logic [10:0] w_prod;

    assign w_prod = 11'(w_head[3:0]) * 11'(w_head[7:4]);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_shadow <= 11'd0;
        end else if (r_state == S_CLEAR) begin
            r_shadow <= 11'd0;
        end else if (w_pop) begin
            r_shadow <= r_shadow + w_prod;
        end
    end

    assign res_ovf = (r_state == S_DONE) && (r_shadow > 11'd255);
`endif

endmodule

// File: tb/tb_mac_operand_sequencer.sv
module tb_mac_operand_sequencer;

    localparam int DEPTH = 8;
    localparam int LEN_W = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             in_valid = 1'b0;
    logic [7:0]       in_data = 8'd0;
    logic             in_ready;
    logic             start = 1'b0;
    logic [LEN_W-1:0] len = '0;
    logic             busy;
    logic [3:0]       mac_a;
    logic [3:0]       mac_b;
    logic             mac_clr;
    logic [7:0]       mac_c;
    logic             res_valid;
    logic [7:0]       res_data;
    logic             res_ready = 1'b0;
`ifdef MAC_SEQ_OVF_FLAG_EN
    logic             res_ovf;
`endif

    mac_operand_sequencer #(.DEPTH(DEPTH), .LEN_W(LEN_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .start     (start),
        .len       (len),
        .busy      (busy),
        .mac_a     (mac_a),
        .mac_b     (mac_b),
        .mac_clr   (mac_clr),
        .mac_c     (mac_c),
        .res_valid (res_valid),
        .res_data  (res_data),
        .res_ready (res_ready)
`ifdef MAC_SEQ_OVF_FLAG_EN
        ,
        .res_ovf   (res_ovf)
`endif
    );

    always #5 clk = ~clk;

    // External accumulator: clear on mac_clr, otherwise add the product, 8-bit wrap.
    logic [7:0] acc = 8'd0;
    assign mac_c = acc;
    always @(posedge clk) begin
        if (mac_clr) acc <= 8'd0;
        else         acc <= acc + {4'b0, mac_a} * {4'b0, mac_b};
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: pairs form one ordered stream; each accepted job takes
    // the next min(len, DEPTH) pairs of that stream and its result is the sum
    // of their products modulo 256.
    // ------------------------------------------------------------------
    logic [7:0] mq[$];
    int         exp_q[$];
    bit         exp_ovf_q[$];
    bit         job_active = 1'b0;
    bit         job_posted = 1'b0;
    int         job_need   = 0;
    int         job_sum    = 0;

    always @(negedge clk) begin
        logic [7:0] p;
        if (rst) begin
            mq.delete();
            exp_q.delete();
            exp_ovf_q.delete();
            job_active = 1'b0;
            job_posted = 1'b0;
        end else begin
            if (in_valid && in_ready) mq.push_back(in_data);
            if (start && !job_active) begin
                job_active = 1'b1;
                job_posted = 1'b0;
                job_need   = (int'(len) > DEPTH) ? DEPTH : int'(len);
                job_sum    = 0;
            end
            while (job_active && !job_posted && job_need > 0 && mq.size() > 0) begin
                p = mq.pop_front();
                job_sum += int'(p[3:0]) * int'(p[7:4]);
                job_need--;
            end
            if (job_active && !job_posted && job_need == 0) begin
                exp_q.push_back(job_sum % 256);
                exp_ovf_q.push_back(job_sum > 255);
                job_posted = 1'b1;
            end
            if (res_valid && res_ready) job_active = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Monitor: compares each accepted result and checks hold stability.
    // ------------------------------------------------------------------
    bit         hold_prev = 1'b0;
    logic [7:0] held_data = 8'd0;

    always @(negedge clk) begin
        int  e;
        bit  eo;
        if (rst) begin
            hold_prev = 1'b0;
        end else if (res_valid) begin
            if (hold_prev) check("res_data_hold", res_data, held_data);
            if (res_ready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL res_unexpected: got result %0d with nothing expected", res_data);
                end else begin
                    e  = exp_q.pop_front();
                    eo = exp_ovf_q.pop_front();
                    check("res_data", res_data, e);
`ifdef MAC_SEQ_OVF_FLAG_EN
                    check("res_ovf", res_ovf, eo);
`endif
                end
            end
            hold_prev = !res_ready;
            held_data = res_data;
        end else begin
            hold_prev = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] d);
        in_valid = 1'b1;
        in_data  = d;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic start_job(input int n);
        start = 1'b1;
        len   = LEN_W'(n);
        tick();
        start = 1'b0;
    endtask

    // Counts negedges after the start edge until res_valid; k = -1 on timeout.
    task automatic wait_valid(output int k, output int clr_first, output int clr_cnt);
        k = 0;
        clr_first = -1;
        clr_cnt = 0;
        do begin
            @(negedge clk);
            k++;
            if (mac_clr) begin
                clr_cnt++;
                if (clr_first < 0) clr_first = k;
            end
        end while (!res_valid && k < 300);
        if (!res_valid) k = -1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_in_ready"},  in_ready,  1);
        check({tag, "_busy"},      busy,      0);
        check({tag, "_mac_a"},     mac_a,     0);
        check({tag, "_mac_b"},     mac_b,     0);
        check({tag, "_mac_clr"},   mac_clr,   0);
        check({tag, "_res_valid"}, res_valid, 0);
        check({tag, "_res_data"},  res_data,  0);
`ifdef MAC_SEQ_OVF_FLAG_EN
        check({tag, "_res_ovf"},   res_ovf,   0);
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int k, cf, cc, first_k;
        bit done;
        int cycles;

        // Reset state
        repeat (2) @(negedge clk);
        check_reset_outputs("reset");
        tick();
        rst = 1'b0;
        res_ready = 1'b1;

        // Basic job: 3*4 + 2*5 = 22
        push(8'h43);
        push(8'h52);
        start_job(2);
        wait_valid(k, cf, cc);
        check("t1_clr_cycle", cf, 1);
        check("t1_clr_count", cc, 1);
        check("t1_latency", k, 5);
        check("t1_data", res_data, 22);
        tick();

        // Stalls: {1,1} present, {2,2} pushed in cycle 4, {3,3} in cycle 6
        push(8'h11);
        start_job(3);
        first_k = -1;
        for (int c = 1; c <= 20; c++) begin
            in_valid = (c == 4 || c == 6);
            in_data  = (c == 4) ? 8'h22 : 8'h33;
            @(negedge clk);
            if (c == 3 || c == 4 || c == 6) begin
                check($sformatf("t2_stall_a_c%0d", c), mac_a, 0);
                check($sformatf("t2_stall_b_c%0d", c), mac_b, 0);
            end
            if (c == 2) check("t2_op_a_c2", mac_a, 1);
            if (c == 5) check("t2_op_a_c5", mac_a, 2);
            if (c == 7) check("t2_op_b_c7", mac_b, 3);
            if (res_valid) begin
                first_k = c;
                check("t2_data", res_data, 14);
                break;
            end
            tick();
        end
        in_valid = 1'b0;
        check("t2_latency", first_k, 9);
        tick();

        // Full FIFO: 8 x {15,15}, extra push ignored, 1800 mod 256 = 8
        for (int i = 0; i < DEPTH; i++) push(8'hFF);
        @(negedge clk);
        check("t3_full_in_ready", in_ready, 0);
        tick();
        push(8'h11);
        @(negedge clk);
        check("t3_still_full", in_ready, 0);
        tick();
        start_job(8);
        wait_valid(k, cf, cc);
        check("t3_latency", k, 11);
        check("t3_data", res_data, 8);
`ifdef MAC_SEQ_OVF_FLAG_EN
        check("t3_ovf", res_ovf, 1);
`endif
        tick();
        @(negedge clk);
        check("t3_drained_in_ready", in_ready, 1);
        tick();

        // len = 0 leaves the FIFO untouched; following len=1 job uses {1,2}
        push(8'h21);
        start_job(0);
        wait_valid(k, cf, cc);
        check("t4_latency", k, 3);
        check("t4_data", res_data, 0);
        check("t4_clr_cycle", cf, 1);
        tick();
        start_job(1);
        wait_valid(k, cf, cc);
        check("t4b_latency", k, 4);
        check("t4b_data", res_data, 2);
        tick();

        // Reset in cycle 3 of a len=4 job
        push(8'h11);
        push(8'h22);
        push(8'h33);
        push(8'h44);
        start_job(4);
        tick();
        tick();
        rst = 1'b1;
        @(negedge clk);
        check_reset_outputs("midrst");
        tick();
        rst = 1'b0;
        push(8'h32);
        start_job(1);
        wait_valid(k, cf, cc);
        check("t5_latency", k, 4);
        check("t5_data", res_data, 6);
        tick();

        // Held result with res_ready low and start pulsing
        res_ready = 1'b0;
        push(8'h65);
        start_job(1);
        wait_valid(k, cf, cc);
        check("t6_data", res_data, 30);
        for (int i = 0; i < 5; i++) begin
            tick();
            start = (i % 2 == 0);
            len   = LEN_W'(2);
            @(negedge clk);
            check($sformatf("t6_hold_valid_%0d", i), res_valid, 1);
            check($sformatf("t6_hold_data_%0d", i), res_data, 30);
        end
        tick();
        start = 1'b0;
        res_ready = 1'b1;
        @(negedge clk);
        tick();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check($sformatf("t6_idle_busy_%0d", i), busy, 0);
            tick();
        end

        // Randomized jobs with random pushes and result backpressure
        for (int j = 0; j < 40; j++) begin
            start_job(int'($urandom_range(0, 15)));
            done = 1'b0;
            cycles = 0;
            while (!done && cycles < 400) begin
                in_valid  = ($urandom % 3) != 0;
                in_data   = 8'($urandom);
                res_ready = ($urandom % 2) != 0;
                @(negedge clk);
                if (res_valid && res_ready) done = 1'b1;
                tick();
                cycles++;
            end
            in_valid  = 1'b0;
            res_ready = 1'b1;
            if (!done) begin
                n_checks++;
                n_fail++;
                $display("FAIL rand_timeout: job %0d gave no result within %0d cycles", j, cycles);
            end
        end

        repeat (2) tick();
        check("scoreboard_empty", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
